// File: rtl/ldm_writeback_seq_if.sv
// Bus bundle for the multi-register load sequencer: control, DMEM read port and
// register-file write port, with master (sequencer) and slave (environment) views.
interface ldm_writeback_seq_if #(
  parameter int NREGS = 16
);
  localparam int IW = $clog2(NREGS);

  // start/reg_list/base_addr/wback_en/base_reg are sampled together on the edge where
  // start=1 and the sequencer is idle; busy covers every read/write cycle and done
  // pulses for one cycle after the final write. A read launched with dmem_rd_en is
  // answered on dmem_rdata in time for the next rising edge.
  logic              start;
  logic [NREGS-1:0]  reg_list;
  logic [31:0]       base_addr;
  logic              wback_en;
  logic [IW-1:0]     base_reg;
  logic              dmem_rd_en;
  logic [31:0]       dmem_addr;
  logic [31:0]       dmem_rdata;
  logic              rf_wr_en;
  logic [IW-1:0]     rf_wr_addr;
  logic [31:0]       rf_wr_data;
  logic              pc_load;
  logic              busy;
  logic              done;

  modport master (
    input  start, reg_list, base_addr, wback_en, base_reg, dmem_rdata,
    output dmem_rd_en, dmem_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    output pc_load, busy, done
  );

  modport slave (
    output start, reg_list, base_addr, wback_en, base_reg, dmem_rdata,
    input  dmem_rd_en, dmem_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  pc_load, busy, done
  );
endinterface

// File: rtl/ldm_writeback_seq.sv
// Multi-register load sequencer: one DMEM read per cycle, each word written to the
// register file one cycle later in ascending order, then optional base writeback.
module ldm_writeback_seq #(
  parameter int ADDR_STEP = 4,
  parameter int NREGS     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ldm_writeback_seq_if.master     bus,
  output logic [1:0]              dbg_state
);
  localparam int IW = $clog2(NREGS);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    WBACK = 2'd3
  } state_e;

  // state names the phase of the current cycle; registered outputs for the next
  // cycle are computed from the transition being taken at the coming edge.
  state_e state, nxt_state;

  logic [NREGS-1:0] pend, pend_d, list_q;
  logic [31:0]      cur_addr, cur_d, base_q;
  logic [CW-1:0]    count, count_d;
  logic             wb_en_q;
  logic [IW-1:0]    base_reg_q;
  logic             pipe_vld, pipe_vld_d;
  logic [IW-1:0]    pipe_idx, pipe_idx_d;

  logic             rd_en_q, rd_en_d;
  logic [31:0]      addr_q, addr_d;
  logic             wr_en_q, wr_en_d;
  logic [IW-1:0]    wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             pc_q, pc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [NREGS-1:0] src_list;
  logic [31:0]      src_addr;
  logic [CW-1:0]    src_count;
  logic [IW-1:0]    k;
  logic             accept;

  function automatic logic [IW-1:0] lowest_set(input logic [NREGS-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  assign accept = (state == IDLE) && bus.start && (bus.reg_list != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (accept) nxt_state = RUN;
      RUN:     if (pend == '0) nxt_state = DRAIN;
      DRAIN:   nxt_state = (wb_en_q && !list_q[base_reg_q]) ? WBACK : IDLE;
      WBACK:   nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    src_list   = (state == IDLE) ? bus.reg_list  : pend;
    src_addr   = (state == IDLE) ? bus.base_addr : cur_addr;
    src_count  = (state == IDLE) ? '0 : count;
    k          = lowest_set(src_list);
    pend_d     = pend;
    cur_d      = cur_addr;
    count_d    = count;
    pipe_vld_d = 1'b0;
    pipe_idx_d = pipe_idx;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pc_d       = 1'b0;
    busy_d     = (nxt_state != IDLE);
    done_d     = ((state != IDLE) && (nxt_state == IDLE)) ||
                 ((state == IDLE) && bus.start && (bus.reg_list == '0));
    if (nxt_state == RUN) begin
      rd_en_d    = 1'b1;
      addr_d     = src_addr;
      pend_d     = src_list & ~({{(NREGS-1){1'b0}}, 1'b1} << k);
      cur_d      = src_addr + 32'(ADDR_STEP);
      count_d    = src_count + CW'(1);
      pipe_vld_d = 1'b1;
      pipe_idx_d = k;
    end
    // Word requested last cycle is on dmem_rdata now; retire it to the register file.
    if (pipe_vld) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pipe_idx;
      wr_data_d = bus.dmem_rdata;
      pc_d      = (pipe_idx == IW'(NREGS - 1));
    end
    if (nxt_state == WBACK) begin
      wr_en_d   = 1'b1;
      wr_addr_d = base_reg_q;
      wr_data_d = base_q + 32'(count) * 32'(ADDR_STEP);
      pc_d      = (base_reg_q == IW'(NREGS - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      list_q     <= '0;
      cur_addr   <= '0;
      base_q     <= '0;
      count      <= '0;
      wb_en_q    <= 1'b0;
      base_reg_q <= '0;
      pipe_vld   <= 1'b0;
      pipe_idx   <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pc_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pend       <= pend_d;
      cur_addr   <= cur_d;
      count      <= count_d;
      pipe_vld   <= pipe_vld_d;
      pipe_idx   <= pipe_idx_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      pc_q       <= pc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (accept) begin
        list_q     <= bus.reg_list;
        base_q     <= bus.base_addr;
        wb_en_q    <= bus.wback_en;
        base_reg_q <= bus.base_reg;
      end
    end
  end

  assign bus.dmem_rd_en = rd_en_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_addr = wr_addr_q;
  assign bus.rf_wr_data = wr_data_q;
  assign bus.pc_load    = pc_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_ldm_writeback_seq.sv
// Directed bench for ldm_writeback_seq: per-cycle expected vectors queued by hand,
// DMEM answered from a data queue, immediate assertions at every comparison.
module tb_ldm_writeback_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  ldm_writeback_seq_if #(.NREGS(16)) bus ();

  ldm_writeback_seq #(.ADDR_STEP(4), .NREGS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  string       tname = "reset";
  logic [72:0] exp_q[$];
  logic [31:0] dm_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", tname, tag, obs, exp);
    end
  endtask

  // Vector layout: {rd_en, rd_addr[32], wr_en, wr_addr[4], wr_data[32], pc_load, busy, done}
  task automatic expect_cyc(input logic rd, input logic [31:0] addr, input logic wr,
                            input logic [3:0] waddr, input logic [31:0] wdata,
                            input logic pc, input logic busy, input logic done);
    exp_q.push_back({rd, addr, wr, waddr, wdata, pc, busy, done});
  endtask

  task automatic exp_done();
    expect_cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic exp_idle();
    expect_cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_op(input logic [15:0] list, input logic [31:0] base,
                          input logic wb, input logic [3:0] br);
    bus.start     = 1'b1;
    bus.reg_list  = list;
    bus.base_addr = base;
    bus.wback_en  = wb;
    bus.base_reg  = br;
  endtask

  task automatic run_cycles(input int n);
    logic [72:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("sb_depth", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_en", 32'(bus.dmem_rd_en), 32'(e[72]));
        if (e[72]) chk("rd_addr", bus.dmem_addr, e[71:40]);
        chk("wr_en", 32'(bus.rf_wr_en), 32'(e[39]));
        if (e[39]) begin
          chk("wr_addr", 32'(bus.rf_wr_addr), 32'(e[38:35]));
          chk("wr_data", bus.rf_wr_data, e[34:3]);
        end
        chk("pc_load", 32'(bus.pc_load), 32'(e[2]));
        chk("busy", 32'(bus.busy), 32'(e[1]));
        chk("done", 32'(bus.done), 32'(e[0]));
      end
      if (bus.dmem_rd_en) bus.dmem_rdata = (dm_q.size() != 0) ? dm_q.pop_front() : 32'hDEAD_BEEF;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"},   32'(bus.dmem_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, bus.dmem_addr,        32'd0);
    chk({tag, "_wr_en"},   32'(bus.rf_wr_en),   32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.rf_wr_addr), 32'd0);
    chk({tag, "_wr_data"}, bus.rf_wr_data,       32'd0);
    chk({tag, "_pc_load"}, 32'(bus.pc_load),    32'd0);
    chk({tag, "_busy"},    32'(bus.busy),       32'd0);
    chk({tag, "_done"},    32'(bus.done),       32'd0);
    chk({tag, "_state"},   32'(dbg_state),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.reg_list   = 16'h0;
    bus.base_addr  = 32'h0;
    bus.wback_en   = 1'b0;
    bus.base_reg   = 4'h0;
    bus.dmem_rdata = 32'h0;
    #1;
    check_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_idle();
    run_cycles(1);

    // Three plain loads, no writeback
    tname = "t1_list7";
    dm_q = '{32'hA0, 32'hA1, 32'hA2};
    start_op(16'h0007, 32'h100, 1'b0, 4'h0);
    expect_cyc(1'b1, 32'h100, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 1'b0);
    expect_cyc(1'b1, 32'h104, 1'b1, 4'h0, 32'hA0, 1'b0, 1'b1, 1'b0);
    expect_cyc(1'b1, 32'h108, 1'b1, 4'h1, 32'hA1, 1'b0, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,   1'b1, 4'h2, 32'hA2, 1'b0, 1'b1, 1'b0);
    exp_done();
    exp_idle();
    run_cycles(6);

    // r0 + r15 (pc_load) then base writeback r4 = 0x200 + 8
    tname = "t2_pc_wback";
    dm_q = '{32'h1111_0000, 32'h2222_000F};
    start_op(16'h8001, 32'h200, 1'b1, 4'h4);
    expect_cyc(1'b1, 32'h200, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0);
    expect_cyc(1'b1, 32'h204, 1'b1, 4'h0, 32'h1111_0000, 1'b0, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,   1'b1, 4'hF, 32'h2222_000F, 1'b1, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,   1'b1, 4'h4, 32'h208,       1'b0, 1'b1, 1'b0);
    exp_done();
    exp_idle();
    run_cycles(6);

    // Base register in the list: loaded value wins, writeback suppressed
    tname = "t3_base_in_list";
    dm_q = '{32'h0000_0044};
    start_op(16'h0010, 32'h300, 1'b1, 4'h4);
    expect_cyc(1'b1, 32'h300, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,   1'b1, 4'h4, 32'h44, 1'b0, 1'b1, 1'b0);
    exp_done();
    exp_idle();
    run_cycles(4);

    // Empty list: immediate done, nothing else
    tname = "t4_empty";
    start_op(16'h0000, 32'h123, 1'b1, 4'h2);
    exp_done();
    exp_idle();
    exp_idle();
    run_cycles(3);

    // Address wrap through 2^32, writeback r5 = 0xFFFFFFFC + 8
    tname = "t5_wrap";
    dm_q = '{32'h5050_0000, 32'h5151_0001};
    start_op(16'h0003, 32'hFFFF_FFFC, 1'b1, 4'h5);
    expect_cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0);
    expect_cyc(1'b1, 32'h0000_0000, 1'b1, 4'h0, 32'h5050_0000, 1'b0, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,         1'b1, 4'h1, 32'h5151_0001, 1'b0, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,         1'b1, 4'h5, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
    exp_done();
    exp_idle();
    run_cycles(6);

    // Back-to-back: start accepted in the done cycle
    tname = "t7_b2b";
    dm_q = '{32'h61, 32'h7E};
    start_op(16'h0001, 32'h600, 1'b0, 4'h0);
    expect_cyc(1'b1, 32'h600, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,   1'b1, 4'h0, 32'h61, 1'b0, 1'b1, 1'b0);
    exp_done();
    run_cycles(3);
    start_op(16'h4000, 32'h700, 1'b0, 4'h0);
    expect_cyc(1'b1, 32'h700, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,   1'b1, 4'hE, 32'h7E, 1'b0, 1'b1, 1'b0);
    exp_done();
    exp_idle();
    run_cycles(4);

    // Start while busy is ignored, then reset aborts mid-run
    tname = "t6_abort";
    dm_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7};
    start_op(16'h00FF, 32'h400, 1'b1, 4'h9);
    expect_cyc(1'b1, 32'h400, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 1'b0);
    expect_cyc(1'b1, 32'h404, 1'b1, 4'h0, 32'hB0, 1'b0, 1'b1, 1'b0);
    expect_cyc(1'b1, 32'h408, 1'b1, 4'h1, 32'hB1, 1'b0, 1'b1, 1'b0);
    run_cycles(3);
    start_op(16'h0001, 32'h999, 1'b0, 4'h0);
    expect_cyc(1'b1, 32'h40C, 1'b1, 4'h2, 32'hB2, 1'b0, 1'b1, 1'b0);
    expect_cyc(1'b1, 32'h410, 1'b1, 4'h3, 32'hB3, 1'b0, 1'b1, 1'b0);
    run_cycles(2);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) begin
      @(negedge clk);
      check_zero("held_rst");
    end
    rst_n = 1'b1;
    dm_q.delete();
    exp_idle();
    exp_idle();
    run_cycles(2);

    tname = "t6_restart";
    dm_q = '{32'hC1, 32'hC2};
    start_op(16'h0006, 32'h500, 1'b0, 4'h0);
    expect_cyc(1'b1, 32'h500, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 1'b0);
    expect_cyc(1'b1, 32'h504, 1'b1, 4'h1, 32'hC1, 1'b0, 1'b1, 1'b0);
    expect_cyc(1'b0, 32'h0,   1'b1, 4'h2, 32'hC2, 1'b0, 1'b1, 1'b0);
    exp_done();
    exp_idle();
    run_cycles(5);

    tname = "end";
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
